dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Sequencer for the 512x16 data memory: accepts one load/store/push/pop request at a time and drives the memory's WR/RD/psh/pop strobes, address and data.
- Owns the 9-bit stack pointer with full/empty protection.
- Returns read data or completion through a valid/ready response.
- Sits between the control unit and the data memory.

Parameters:
N, 16, data width
AW, 9, address / stack pointer width
SP_TOP, 511, reset value of the stack pointer (empty stack); stack grows downward
SP_LIMIT, 256, lowest stack slot; stack full when sp == SP_LIMIT-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  2  00 load, 01 store, 10 push, 11 pop
req_addr  in  AW  load/store address
req_wdata  in  N  store/push data
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_data  out  N  load/pop data; 0 for store/push/error
rsp_err  out  1  push on full or pop on empty
mem_WR  out  1  memory write strobe
mem_RD  out  1  memory read strobe
mem_psh  out  1  memory push strobe
mem_pop  out  1  memory pop strobe
mem_address  out  AW  memory address
mem_data_in  out  N  memory write data
mem_stackpointer  out  AW  current sp to memory
mem_data_out  in  N  registered read data from memory
sp  out  AW  current stack pointer
stack_empty  out  1  sp == SP_TOP
stack_full  out  1  sp == SP_LIMIT-1

Behaviour:
- Reset (async, any state): state IDLE, sp=SP_TOP, all strobes 0, rsp_valid=0, rsp_err=0, rsp_data=0, mem_address=0, mem_data_in=0. An in-flight transaction is dropped; no strobe may be emitted after reset asserts.
- All outputs are registered except stack_empty/stack_full, which decode sp; mem_stackpointer = sp.
- FSM states: IDLE, ISSUE, CAPT, RESP.
- req_ready = 1 only in IDLE. A request is accepted on an edge with req_valid && req_ready; op/addr/wdata are latched then.
- IDLE:
  - Accepted push with stack_full, or pop with stack_empty -> RESP with rsp_err=1, rsp_data=0, no strobe, sp unchanged.
  - Any other accepted request -> ISSUE.
- ISSUE (exactly 1 cycle), exactly one strobe high per op:
  - load: mem_RD=1, mem_address=addr.
  - store: mem_WR=1, mem_address=addr, mem_data_in=wdata.
  - push: mem_psh=1, mem_data_in=wdata; memory writes mem[sp]. sp decrements at the end of ISSUE.
  - pop: mem_pop=1; memory reads mem[sp+1]. sp increments at the end of ISSUE.
  - -> CAPT.
- CAPT (1 cycle):
  - All strobes 0.
  - load/pop: rsp_data <= mem_data_out at the end of CAPT.
  - store/push: rsp_data <= 0.
  - -> RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err held stable until rsp_valid && rsp_ready.
  - On that handshake: -> IDLE, rsp_valid=0, rsp_err=0.
- Latency from accept edge: rsp_valid is high in the 3rd cycle after accept (1st on the error path). Minimum throughput is 1 request per 4 cycles with rsp_ready tied high.
- sp arithmetic is modulo 2^AW. Wrap never occurs in practice because the full/empty checks block it.
- Load/store addresses are not range-checked and may alias the stack region.
- req_op and req_addr are ignored outside an accept edge.

Test Plan:
- Reset, then idle: sp=511, stack_empty=1, stack_full=0, req_ready=1, all strobes 0.
- Store 0xBEEF @0x012, then load @0x012:
  - mem_WR pulses 1 cycle with address 0x012.
  - Load response rsp_data=0xBEEF, rsp_err=0, rsp_valid in the 3rd cycle after accept.
- Push 0x1111, push 0x2222, pop, pop:
  - sp goes 511->510->509->510->511.
  - Pops return 0x2222 then 0x1111.
  - mem_psh/mem_pop each high exactly 1 cycle per op.
- Pop on empty stack: rsp_err=1, rsp_data=0, rsp_valid the cycle after accept, no strobe, sp stays 511.
- Push 256 words (0..255): stack_full=1 with sp=255. A 257th push gets rsp_err=1 and no mem_psh. A following pop returns 255.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid/rsp_data stable, req_ready=0.
  - Assert rst mid-ISSUE of a push: strobe drops immediately, sp=511, state IDLE.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory sequencer: serialises load/store/push/pop requests onto the
// memory strobes, owns the downward-growing stack pointer, returns a valid/ready response.
module dmem_ctrl #(
  parameter int N        = 16,
  parameter int AW       = 9,
  parameter int SP_TOP   = 511,
  parameter int SP_LIMIT = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [N-1:0]  req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          rsp_err,
  output logic          mem_WR,
  output logic          mem_RD,
  output logic          mem_psh,
  output logic          mem_pop,
  output logic [AW-1:0] mem_address,
  output logic [N-1:0]  mem_data_in,
  output logic [AW-1:0] mem_stackpointer,
  input  logic [N-1:0]  mem_data_out,
  output logic [AW-1:0] sp,
  output logic          stack_empty,
  output logic          stack_full
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_PUSH, OP_POP} op_t;

  state_t state, next_state;
  op_t    op_q, op_d, req_op_e;
  logic   accept, acc_err;

  logic          wr_d, rd_d, psh_d, pop_d, rsp_err_d;
  logic [AW-1:0] addr_d, sp_d;
  logic [N-1:0]  din_d, rsp_data_d;

  assign req_op_e         = op_t'(req_op);
  assign stack_empty      = (sp == AW'(SP_TOP));
  assign stack_full       = (sp == AW'(SP_LIMIT - 1));
  assign mem_stackpointer = sp;
  assign accept           = req_valid && req_ready;
  assign acc_err          = ((req_op_e == OP_PUSH) && stack_full) ||
                            ((req_op_e == OP_POP)  && stack_empty);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (accept) next_state = acc_err ? RESP : ISSUE;
      ISSUE: next_state = CAPT;
      CAPT:  next_state = RESP;
      RESP:  if (rsp_ready) next_state = IDLE;
    endcase
  end

  // Next values for the registered outputs; strobes are computed one cycle
  // early so they are high exactly during ISSUE.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    psh_d      = 1'b0;
    pop_d      = 1'b0;
    addr_d     = mem_address;
    din_d      = mem_data_in;
    sp_d       = sp;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    op_d       = op_q;
    unique case (state)
      IDLE: if (accept) begin
        op_d = req_op_e;
        if (acc_err) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          unique case (req_op_e)
            OP_LOAD:  begin rd_d  = 1'b1; addr_d = req_addr; end
            OP_STORE: begin wr_d  = 1'b1; addr_d = req_addr; din_d = req_wdata; end
            OP_PUSH:  begin psh_d = 1'b1; din_d  = req_wdata; end
            OP_POP:   pop_d = 1'b1;
          endcase
        end
      end
      ISSUE: begin
        if (op_q == OP_PUSH) sp_d = sp - 1'b1;
        if (op_q == OP_POP)  sp_d = sp + 1'b1;
      end
      CAPT: begin
        rsp_data_d = ((op_q == OP_LOAD) || (op_q == OP_POP)) ? mem_data_out : '0;
        rsp_err_d  = 1'b0;
      end
      RESP: if (rsp_ready) rsp_err_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= OP_LOAD;
      sp          <= AW'(SP_TOP);
      mem_WR      <= 1'b0;
      mem_RD      <= 1'b0;
      mem_psh     <= 1'b0;
      mem_pop     <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_valid   <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      op_q        <= op_d;
      sp          <= sp_d;
      mem_WR      <= wr_d;
      mem_RD      <= rd_d;
      mem_psh     <= psh_d;
      mem_pop     <= pop_d;
      mem_address <= addr_d;
      mem_data_in <= din_d;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
      rsp_valid   <= (next_state == RESP);
      req_ready   <= (next_state == IDLE);
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural 512x16 registered-read memory.
module tb_dmem_ctrl;

  localparam logic [1:0] LD = 2'b00, ST = 2'b01, PU = 2'b10, PO = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [1:0]  req_op = 2'b00;
  logic [8:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] rsp_data, mem_data_in;
  logic [15:0] mem_data_out = '0;
  logic        mem_WR, mem_RD, mem_psh, mem_pop;
  logic [8:0]  mem_address, mem_stackpointer, sp;
  logic        stack_empty, stack_full;

  logic [15:0] mem [512];
  int n_cmp = 0, n_fail = 0;
  int wr_cnt = 0, rd_cnt = 0, psh_cnt = 0, pop_cnt = 0;
  logic [8:0] wr_addr = '0;

  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_WR(mem_WR), .mem_RD(mem_RD), .mem_psh(mem_psh), .mem_pop(mem_pop),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_stackpointer(mem_stackpointer), .mem_data_out(mem_data_out),
    .sp(sp), .stack_empty(stack_empty), .stack_full(stack_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_WR)  mem[mem_address] <= mem_data_in;
    if (mem_psh) mem[mem_stackpointer] <= mem_data_in;
    if (mem_RD)  mem_data_out <= mem[mem_address];
    if (mem_pop) mem_data_out <= mem[mem_stackpointer + 9'd1];
  end

  always @(negedge clk) begin
    if (mem_WR) begin wr_cnt++; wr_addr = mem_address; end
    if (mem_RD)  rd_cnt++;
    if (mem_psh) psh_cnt++;
    if (mem_pop) pop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts and ends on a negedge in IDLE; rsp_ready is expected high.
  task automatic do_req(input logic [1:0] op, input logic [8:0] addr, input logic [15:0] wd,
                        output logic [15:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    wr_cnt = 0; rd_cnt = 0; psh_cnt = 0; pop_cnt = 0;
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    rd = rsp_data;
    er = rsp_err;
    @(negedge clk);
  endtask

  logic [15:0] d;
  logic        e;
  int          lat, errs;
  logic        stable;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sp", sp, 9'd511);
    check("rst_empty_full", {stack_empty, stack_full}, 2'b10);
    check("rst_ready_valid", {req_ready, rsp_valid, rsp_err}, 3'b100);
    check("rst_strobes", {mem_WR, mem_RD, mem_psh, mem_pop}, 4'b0000);

    do_req(ST, 9'h012, 16'hBEEF, d, e, lat);
    check("st_wr_pulses", wr_cnt, 1);
    check("st_wr_addr", wr_addr, 9'h012);
    check("st_other_strobes", rd_cnt + psh_cnt + pop_cnt, 0);
    check("st_rsp", {e, d}, {1'b0, 16'h0000});
    check("st_lat", lat, 3);

    do_req(LD, 9'h012, 16'h0000, d, e, lat);
    check("ld_rsp", {e, d}, {1'b0, 16'hBEEF});
    check("ld_lat", lat, 3);
    check("ld_rd_pulses", rd_cnt, 1);

    do_req(PU, 9'h000, 16'h1111, d, e, lat);
    check("push1_sp", sp, 9'd510);
    check("push1_psh_pulses", psh_cnt, 1);
    do_req(PU, 9'h000, 16'h2222, d, e, lat);
    check("push2_sp", sp, 9'd509);
    do_req(PO, 9'h000, 16'h0000, d, e, lat);
    check("pop1_rsp", {e, d}, {1'b0, 16'h2222});
    check("pop1_sp", sp, 9'd510);
    check("pop1_pop_pulses", pop_cnt, 1);
    do_req(PO, 9'h000, 16'h0000, d, e, lat);
    check("pop2_rsp", {e, d}, {1'b0, 16'h1111});
    check("pop2_sp_empty", {sp, stack_empty}, {9'd511, 1'b1});

    do_req(PO, 9'h000, 16'h0000, d, e, lat);
    check("pop_empty_rsp", {e, d}, {1'b1, 16'h0000});
    check("pop_empty_lat", lat, 1);
    check("pop_empty_strobes", wr_cnt + rd_cnt + psh_cnt + pop_cnt, 0);
    check("pop_empty_sp", sp, 9'd511);
    check("err_cleared", {rsp_err, req_ready}, 2'b01);

    errs = 0;
    for (int i = 0; i < 256; i++) begin
      do_req(PU, 9'h000, 16'(i), d, e, lat);
      if (e) errs++;
    end
    check("fill_errs", errs, 0);
    check("fill_sp_full", {sp, stack_full, stack_empty}, {9'd255, 1'b1, 1'b0});
    do_req(PU, 9'h000, 16'hDEAD, d, e, lat);
    check("push_full_rsp", {e, d}, {1'b1, 16'h0000});
    check("push_full_no_psh", psh_cnt, 0);
    check("push_full_sp", sp, 9'd255);
    do_req(PO, 9'h000, 16'h0000, d, e, lat);
    check("pop_after_full", {e, d}, {1'b0, 16'd255});
    check("pop_after_full_sp", {sp, stack_full}, {9'd256, 1'b0});

    // Response held under backpressure.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = LD; req_addr = 9'h012;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", lat, 3);
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (!(rsp_valid === 1'b1 && rsp_data === 16'hBEEF && req_ready === 1'b0)) stable = 1'b0;
      @(negedge clk);
    end
    check("bp_stable", stable, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {rsp_valid, req_ready}, 2'b01);

    // Reset asserted in the middle of a push's ISSUE cycle.
    req_valid = 1'b1; req_op = PU; req_wdata = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("issue_psh_high", mem_psh, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_strobe", {mem_WR, mem_RD, mem_psh, mem_pop}, 4'b0000);
    check("rst_mid_sp", sp, 9'd511);
    check("rst_mid_idle", {req_ready, rsp_valid}, 2'b10);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_strobes", {mem_WR, mem_RD, mem_psh, mem_pop, sp}, {4'b0000, 9'd511});
    do_req(PO, 9'h000, 16'h0000, d, e, lat);
    check("post_rst_pop_empty", {e, d}, {1'b1, 16'h0000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
